// File: rtl/tile_draw_scheduler.sv
// ============================================================================
// Module   : tile_draw_scheduler
// Purpose  : Round-robin scheduler that drives the tile drawer one tile at a
//            time. Optional draw watchdog: define TILE_SCHED_WDOG_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tile_draw_scheduler #(
  parameter int         NUM_TILES   = 9,
  parameter int         COL_W       = 3,
  parameter logic [3:0] PARK_LOC    = 4'hF,
  parameter int         WDOG_CYCLES = 2048
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_TILES-1:0]       dirty_set,
  input  logic                       refresh_all,
  input  logic [NUM_TILES*COL_W-1:0] tile_colours,
  input  logic                       draw_finished,
  output logic [3:0]                 draw_location,
  output logic [COL_W-1:0]           draw_colour,
  output logic                       draw_enable,
  output logic                       busy,
  output logic                       frame_done,
  output logic [NUM_TILES-1:0]       pending,
  output logic                       wdog_err
);

  localparam logic [3:0] c_last_tile = 4'(NUM_TILES - 1);

  if (NUM_TILES < 1 || NUM_TILES > 15 || WDOG_CYCLES < 2) begin : g_param_check
    $error("tile_draw_scheduler: unsupported parameter values");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PARK = 3'd1,
    S_ARM  = 3'd2,
    S_DRAW = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              r_state;
  logic [3:0]          r_cur_tile;
  logic [3:0]          r_rr_ptr;

  logic [NUM_TILES-1:0] w_clr;
  logic [NUM_TILES-1:0] w_pend_next;
  logic [3:0]           w_next_ptr;
  logic [3:0]           w_pick_idle;
  logic [3:0]           w_pick_done;
  logic [COL_W-1:0]     w_colour;
  logic                 w_wdog_trip;

  // Lowest set bit at or above base, else lowest set bit overall.
  function automatic logic [3:0] f_pick(input logic [NUM_TILES-1:0] mask,
                                        input logic [3:0]           base);
    logic [3:0] lo_any;
    logic [3:0] lo_hi;
    logic       hi_found;
    lo_any   = 4'd0;
    lo_hi    = 4'd0;
    hi_found = 1'b0;
    for (int i = NUM_TILES - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lo_any = 4'(i);
        if (4'(i) >= base) begin
          lo_hi    = 4'(i);
          hi_found = 1'b1;
        end
      end
    end
    return hi_found ? lo_hi : lo_any;
  endfunction

  always_comb begin
    w_clr = '0;
    if (r_state == S_DONE) begin
      w_clr = {{(NUM_TILES-1){1'b0}}, 1'b1} << r_cur_tile;
    end
    // A request arriving in the same cycle as the clear wins, so the tile is redrawn.
    w_pend_next = (pending & ~w_clr) | dirty_set | {NUM_TILES{refresh_all}};
    w_next_ptr  = (r_cur_tile == c_last_tile) ? 4'd0 : r_cur_tile + 4'd1;
    w_pick_idle = f_pick(pending, r_rr_ptr);
    w_pick_done = f_pick(w_pend_next, w_next_ptr);
    w_colour    = tile_colours[r_cur_tile*COL_W +: COL_W];
  end

`ifdef TILE_SCHED_WDOG_EN
  localparam int c_wdog_w = $clog2(WDOG_CYCLES + 1);

  logic [c_wdog_w-1:0] r_wdog_cnt;
  logic                r_wdog_err;

  assign w_wdog_trip = (r_state == S_DRAW) && !draw_finished &&
                       (r_wdog_cnt == c_wdog_w'(WDOG_CYCLES - 1));
  assign wdog_err    = r_wdog_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdog_cnt <= '0;
      r_wdog_err <= 1'b0;
    end else begin
      if (r_state != S_DRAW) begin
        r_wdog_cnt <= '0;
      end else begin
        r_wdog_cnt <= r_wdog_cnt + 1'b1;
      end
      if (w_wdog_trip) begin
        r_wdog_err <= 1'b1;
      end
    end
  end
`else
  assign w_wdog_trip = 1'b0;
  assign wdog_err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cur_tile    <= 4'd0;
      r_rr_ptr      <= 4'd0;
      pending       <= '0;
      draw_location <= PARK_LOC;
      draw_colour   <= '0;
      draw_enable   <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      pending    <= w_pend_next;
      frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|pending) begin
            r_cur_tile    <= w_pick_idle;
            r_state       <= S_PARK;
            busy          <= 1'b1;
            draw_location <= PARK_LOC;
            draw_enable   <= 1'b0;
          end
        end
        // Stepping off PARK_LOC onto the tile is what restarts the drawer.
        S_PARK: begin
          draw_location <= r_cur_tile;
          r_state       <= S_ARM;
        end
        S_ARM: begin
          draw_colour <= w_colour;
          draw_enable <= 1'b1;
          r_state     <= S_DRAW;
        end
        S_DRAW: begin
          if (draw_finished || w_wdog_trip) begin
            draw_enable <= 1'b0;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          r_rr_ptr      <= w_next_ptr;
          draw_location <= PARK_LOC;
          if (|w_pend_next) begin
            r_cur_tile <= w_pick_done;
            r_state    <= S_PARK;
          end else begin
            r_state    <= S_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          busy          <= 1'b0;
          draw_enable   <= 1'b0;
          draw_location <= PARK_LOC;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tile_draw_scheduler.sv
// ============================================================================
// Module   : tb_tile_draw_scheduler
// Purpose  : Scoreboard bench for tile_draw_scheduler with a stub tile drawer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tile_draw_scheduler;

  localparam int NT       = 9;
  localparam int DRAW_LEN = 12;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NT-1:0]   dirty_set = '0;
  logic            refresh_all = 1'b0;
  logic [NT*3-1:0] tile_colours = '0;
  logic            draw_finished = 1'b0;
  logic [3:0]      draw_location;
  logic [2:0]      draw_colour;
  logic            draw_enable;
  logic            busy;
  logic            frame_done;
  logic [NT-1:0]   pending;
  logic            wdog_err;

  tile_draw_scheduler dut (
    .clk(clk), .reset(reset), .dirty_set(dirty_set), .refresh_all(refresh_all),
    .tile_colours(tile_colours), .draw_finished(draw_finished),
    .draw_location(draw_location), .draw_colour(draw_colour),
    .draw_enable(draw_enable), .busy(busy), .frame_done(frame_done),
    .pending(pending), .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  logic [2:0] c_col [NT] = '{3'd1, 3'd6, 3'd3, 3'd0, 3'd5, 3'd2, 3'd7, 3'd4, 3'd1};

  typedef struct {
    int         kind;   // 0 = draw start, 1 = frame_done
    logic [3:0] loc;
    logic [2:0] col;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push_draw(input int t);
    exp_q.push_back('{0, 4'(t), c_col[t]});
  endtask

  task automatic push_frame();
    exp_q.push_back('{1, 4'd0, 3'd0});
  endtask

  // Stub drawer: counts enabled cycles, raises a sticky finished flag, and
  // restarts whenever the location changes.
  logic       s_hang = 1'b0;
  logic [3:0] s_last_loc = 4'hF;
  int         s_cnt = 0;
  always @(negedge clk) begin
    if (draw_location != s_last_loc) begin
      s_cnt         = 0;
      draw_finished = 1'b0;
    end else if (draw_enable && !draw_finished && !s_hang) begin
      s_cnt++;
      if (s_cnt >= DRAW_LEN) draw_finished = 1'b1;
    end
    s_last_loc = draw_location;
  end

  // Monitor: pops the scoreboard on every draw start and frame_done pulse.
  logic       m_prev_en = 1'b0;
  logic [3:0] m_loc1 = 4'hF;
  logic [3:0] m_loc2 = 4'hF;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      m_prev_en = 1'b0;
      m_loc1    = 4'hF;
      m_loc2    = 4'hF;
    end else begin
      if (draw_enable && !m_prev_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_draw", 32'(draw_location), 32'hFF);
        end else begin
          e = exp_q.pop_front();
          check("event_kind_draw", 32'd0, 32'(e.kind));
          check("draw_loc", 32'(draw_location), 32'(e.loc));
          check("draw_col", 32'(draw_colour), 32'(e.col));
          check("arm_loc", 32'(m_loc1), 32'(e.loc));
          check("park_loc", 32'(m_loc2), 32'hF);
        end
      end
      if (frame_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("event_kind_frame", 32'd1, 32'(e.kind));
        end
      end
      m_prev_en = draw_enable;
      m_loc2    = m_loc1;
      m_loc1    = draw_location;
    end
  end

  task automatic pulse(input logic [NT-1:0] mask, input logic all);
    @(negedge clk);
    dirty_set   = mask;
    refresh_all = all;
    @(negedge clk);
    dirty_set   = '0;
    refresh_all = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_draw(input logic [3:0] t);
    int k = 0;
    while (!(draw_enable === 1'b1 && draw_location === t) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("wait_draw", 32'(draw_enable && draw_location == t), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    int cnt;
    for (int i = 0; i < NT; i++) tile_colours[3*i +: 3] = c_col[i];

    // Reset values
    @(negedge clk);
    check("rst_loc", 32'(draw_location), 32'hF);
    check("rst_col", 32'(draw_colour), 32'd0);
    check("rst_en", 32'(draw_enable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame", 32'(frame_done), 32'd0);
    check("rst_pend", 32'(pending), 32'd0);
    check("rst_wdog", 32'(wdog_err), 32'd0);
    reset = 1'b0;

    // Single tile 4: PARK, ARM, then enable on the third cycle
    push_draw(4); push_frame();
    pulse(9'h010, 1'b0);
    check("t1_pend", 32'(pending), 32'h010);
    check("t1_busy0", 32'(busy), 32'd0);
    @(negedge clk);
    check("t1_park_loc", 32'(draw_location), 32'hF);
    check("t1_park_busy", 32'(busy), 32'd1);
    check("t1_park_en", 32'(draw_enable), 32'd0);
    @(negedge clk);
    check("t1_arm_loc", 32'(draw_location), 32'd4);
    check("t1_arm_en", 32'(draw_enable), 32'd0);
    @(negedge clk);
    check("t1_draw_en", 32'(draw_enable), 32'd1);
    check("t1_draw_loc", 32'(draw_location), 32'd4);
    wait_idle(200);
    check("t1_pend_empty", 32'(pending), 32'd0);
    check("t1_loc_parked", 32'(draw_location), 32'hF);

    // Full refresh from a fresh pointer: 0..8 then one frame_done
    do_reset();
    for (int i = 0; i < NT; i++) push_draw(i);
    push_frame();
    pulse('0, 1'b1);
    check("t2_pend_all", 32'(pending), 32'h1FF);
    @(negedge clk);
    wait_idle(1000);

    // Round robin: 2 and 8 requested while 7 draws -> 7, 8, 2
    push_draw(7);
    pulse(9'h080, 1'b0);
    wait_draw(4'd7);
    push_draw(8); push_draw(2); push_frame();
    pulse(9'h104, 1'b0);
    check("t3_pend", 32'(pending), 32'h184);
    wait_idle(1000);

    // Re-dirty tile 3 in its own DONE cycle
    push_draw(3); push_draw(3); push_frame();
    pulse(9'h008, 1'b0);
    wait_draw(4'd3);
    cnt = 0;
    while (draw_enable && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    dirty_set = 9'h008;
    @(negedge clk);
    dirty_set = '0;
    check("t4_pend3", 32'(pending[3]), 32'd1);
    check("t4_park_loc", 32'(draw_location), 32'hF);
    check("t4_busy", 32'(busy), 32'd1);
    check("t4_no_frame", 32'(frame_done), 32'd0);
    wait_idle(1000);

    // Colour held for the whole draw even if the input changes
    push_draw(5); push_frame();
    pulse(9'h020, 1'b0);
    wait_draw(4'd5);
    tile_colours[15 +: 3] = 3'd7;
    repeat (3) @(negedge clk);
    check("t_col_held", 32'(draw_colour), 32'd2);
    wait_idle(200);
    tile_colours[15 +: 3] = c_col[5];

    // Reset in the middle of a draw
    push_draw(1);
    pulse(9'h002, 1'b0);
    wait_draw(4'd1);
    pulse(9'h100, 1'b0);
    check("t5_pend_before", 32'(pending), 32'h102);
    reset = 1'b1;
    #1;
    check("t5_en", 32'(draw_enable), 32'd0);
    check("t5_loc", 32'(draw_location), 32'hF);
    check("t5_pend", 32'(pending), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("t5_stay_idle", 32'(busy), 32'd0);
    check("t5_stay_en", 32'(draw_enable), 32'd0);

    // Drawer that never finishes
    s_hang = 1'b1;
`ifdef TILE_SCHED_WDOG_EN
    push_draw(0); push_draw(1); push_frame();
    pulse(9'h003, 1'b0);
    wait_draw(4'd0);
    cnt = 0;
    while (draw_enable && cnt < 3000) begin
      cnt++;
      @(negedge clk);
    end
    check("t6_wdog_len", 32'(cnt), 32'd2048);
    check("t6_wdog_err", 32'(wdog_err), 32'd1);
    wait_draw(4'd1);
    wait_idle(3000);
    check("t6_pend", 32'(pending), 32'd0);
`else
    push_draw(0);
    pulse(9'h003, 1'b0);
    wait_draw(4'd0);
    repeat (2100) @(negedge clk);
    check("t6_still_en", 32'(draw_enable), 32'd1);
    check("t6_still_loc", 32'(draw_location), 32'd0);
    check("t6_wdog_err", 32'(wdog_err), 32'd0);
    check("t6_pend", 32'(pending), 32'h003);
    do_reset();
`endif
    s_hang = 1'b0;

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
